// File: rtl/cmd_pkg.sv
// cmd_pkg: shared types and helpers for the TRS-80 /CMD parser.
// State encoding, record type codes and length decode.
package cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_LEN,
    S_ADDR_LO,
    S_ADDR_HI,
    S_DATA,
    S_SKIP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    REC_LOAD,
    REC_XFER,
    REC_SKIP
  } rec_t;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_XFER = 8'h02;

  // Load record length L covers the 2 address bytes; L<3 wraps past 256.
  function automatic logic [8:0] data_count(input logic [7:0] len);
    if (len < 8'd3)
      return {1'b1, len} - 9'd2;
    else
      return {1'b0, len} - 9'd2;
  endfunction

endpackage

// File: rtl/cmd_file_parser.sv
// cmd_file_parser: streams a /CMD image from the ioctl channel
// into RAM writes and requests a jump to the transfer address.
module cmd_file_parser
  import cmd_pkg::*;
#(
  parameter logic [7:0] CMD_INDEX = 8'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        loader_download,
  output logic        loader_wr,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic [15:0] execute_addr,
  output logic        execute_enable,
  output logic        error,
  output logic [31:0] byte_count
);

  state_t      state, n_state, cur;
  rec_t        rec, n_rec;
  logic [7:0]  len, n_len;
  logic [15:0] addr, n_addr;
  logic [8:0]  cnt, n_cnt;
  logic        dl_q, xfer_seen, n_xfer_seen;
  logic        n_loader_wr, n_execute_enable, n_error;
  logic [15:0] n_loader_addr, n_execute_addr;
  logic [7:0]  n_loader_data;
  logic [31:0] n_byte_count, bc_base;
  logic        dl, rise, fall, accept, trunc;

  assign ioctl_wait = 1'b0;
  assign dl     = ioctl_download & (ioctl_index == CMD_INDEX);
  assign rise   = dl & ~dl_q;
  assign fall   = ~dl & dl_q;
  assign accept = ioctl_wr & dl;
  assign trunc  = (state == S_LEN) || (state == S_ADDR_LO) ||
                  (state == S_ADDR_HI) || (state == S_DATA) ||
                  (state == S_SKIP);

  // Register all parser state and outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      rec             <= REC_SKIP;
      len             <= '0;
      addr            <= '0;
      cnt             <= '0;
      dl_q            <= 1'b0;
      xfer_seen       <= 1'b0;
      loader_download <= 1'b0;
      loader_wr       <= 1'b0;
      loader_addr     <= '0;
      loader_data     <= '0;
      execute_addr    <= '0;
      execute_enable  <= 1'b0;
      error           <= 1'b0;
      byte_count      <= '0;
    end else begin
      state           <= n_state;
      rec             <= n_rec;
      len             <= n_len;
      addr            <= n_addr;
      cnt             <= n_cnt;
      dl_q            <= dl;
      xfer_seen       <= n_xfer_seen;
      loader_download <= dl | dl_q;
      loader_wr       <= n_loader_wr;
      loader_addr     <= n_loader_addr;
      loader_data     <= n_loader_data;
      execute_addr    <= n_execute_addr;
      execute_enable  <= n_execute_enable;
      error           <= n_error;
      byte_count      <= n_byte_count;
    end
  end

  // Decode one accepted byte; handle download start and end.
  always_comb begin
    n_state          = state;
    n_rec            = rec;
    n_len            = len;
    n_addr           = addr;
    n_cnt            = cnt;
    n_xfer_seen      = xfer_seen;
    n_loader_wr      = 1'b0;
    n_loader_addr    = loader_addr;
    n_loader_data    = loader_data;
    n_execute_addr   = execute_addr;
    n_execute_enable = 1'b0;
    n_error          = error;
    n_byte_count     = byte_count;
    cur              = state;
    bc_base          = byte_count;

    if (rise) begin
      cur          = S_TYPE;
      n_state      = S_TYPE;
      n_error      = 1'b0;
      n_xfer_seen  = 1'b0;
      bc_base      = '0;
      n_byte_count = '0;
    end

    if (fall) begin
      n_error          = error | trunc;
      n_execute_enable = xfer_seen & ~error & ~trunc;
      n_state          = S_IDLE;
    end else if (accept) begin
      n_byte_count = bc_base + 32'd1;
      case (cur)
        S_TYPE: begin
          unique case (1'b1)
            (ioctl_dout == CMD_LOAD): n_rec = REC_LOAD;
            (ioctl_dout == CMD_XFER): n_rec = REC_XFER;
            default:                  n_rec = REC_SKIP;
          endcase
          n_state = S_LEN;
        end
        S_LEN: begin
          n_len = ioctl_dout;
          if (rec == REC_SKIP) begin
            n_cnt   = {ioctl_dout == 8'd0, ioctl_dout};
            n_state = S_SKIP;
          end else begin
            n_state = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          n_addr[7:0] = ioctl_dout;
          n_state     = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          if (rec == REC_XFER) begin
            n_execute_addr = {ioctl_dout, addr[7:0]};
            n_xfer_seen    = 1'b1;
            n_state        = S_DONE;
          end else begin
            n_addr  = {ioctl_dout, addr[7:0]};
            n_cnt   = data_count(len);
            n_state = S_DATA;
          end
        end
        S_DATA: begin
          n_loader_wr   = 1'b1;
          n_loader_addr = addr;
          n_loader_data = ioctl_dout;
          n_addr        = addr + 16'd1;
          n_cnt         = cnt - 9'd1;
          if (cnt == 9'd1) n_state = S_TYPE;
        end
        S_SKIP: begin
          n_cnt = cnt - 9'd1;
          if (cnt == 9'd1) n_state = S_TYPE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_file_parser.sv
// tb_cmd_file_parser: directed bench for the /CMD parser.
// Writes and jump pulses are logged on the falling edge.
module tb_cmd_file_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        loader_download;
  logic        loader_wr;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        error;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int ex_total = 0;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];

  cmd_file_parser #(.CMD_INDEX(8'd2)) dut (
    .clock(clock),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .loader_download(loader_download),
    .loader_wr(loader_wr),
    .loader_addr(loader_addr),
    .loader_data(loader_data),
    .execute_addr(execute_addr),
    .execute_enable(execute_enable),
    .error(error),
    .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  // Log every write strobe and jump pulse.
  always @(negedge clock) begin
    if (loader_wr) begin
      wr_total++;
      wa.push_back(loader_addr);
      wd.push_back(loader_data);
    end
    if (execute_enable) ex_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] idx);
    @(negedge clock);
    ioctl_wr = 1'b0;
    ioctl_index = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ioctl_wr = 1'b1;
    ioctl_dout = b;
  endtask

  task automatic stop();
    @(negedge clock);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int base, exb, bad;

    repeat (2) @(negedge clock);
    chk("rst_wr", loader_wr, 0);
    chk("rst_addr", loader_addr, 0);
    chk("rst_data", loader_data, 0);
    chk("rst_xaddr", execute_addr, 0);
    chk("rst_xen", execute_enable, 0);
    chk("rst_err", error, 0);
    chk("rst_bc", byte_count, 0);
    chk("rst_ld", loader_download, 0);
    chk("wait", ioctl_wait, 0);
    reset = 1'b0;

    // Basic load + transfer
    base = wr_total; exb = ex_total;
    start(8'd2);
    @(negedge clock);
    chk("ld_rise", loader_download, 1);
    send(8'h01); send(8'h05); send(8'h00); send(8'h40);
    send(8'hAA); send(8'hBB); send(8'hCC);
    @(negedge clock);
    ioctl_wr = 1'b0;
    chk("lat_wr", loader_wr, 1);
    chk("lat_addr", loader_addr, 16'h4002);
    chk("lat_data", loader_data, 8'hCC);
    @(negedge clock);
    chk("hold_wr", loader_wr, 0);
    chk("hold_addr", loader_addr, 16'h4002);
    send(8'h02); send(8'h02); send(8'h00); send(8'h40);
    @(negedge clock);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    chk("t1_bc", byte_count, 11);
    chk("t1_xaddr", execute_addr, 16'h4000);
    @(negedge clock);
    chk("t1_xen", execute_enable, 1);
    chk("t1_ld_hi", loader_download, 1);
    @(negedge clock);
    chk("t1_xen_off", execute_enable, 0);
    chk("t1_ld_lo", loader_download, 0);
    chk("t1_nwr", wr_total - base, 3);
    chk("t1_a0", wa[base], 16'h4000);
    chk("t1_d0", wd[base], 8'hAA);
    chk("t1_a1", wa[base+1], 16'h4001);
    chk("t1_d1", wd[base+1], 8'hBB);
    chk("t1_a2", wa[base+2], 16'h4002);
    chk("t1_d2", wd[base+2], 8'hCC);
    chk("t1_nex", ex_total - exb, 1);
    chk("t1_err", error, 0);

    // L=00 gives 254 bytes, L=02 gives 256 bytes
    base = wr_total; exb = ex_total;
    start(8'd2);
    send(8'h01); send(8'h00); send(8'h00); send(8'h70);
    for (int i = 0; i < 254; i++) send(8'(i));
    send(8'h01); send(8'h02); send(8'h00); send(8'h70);
    for (int i = 0; i < 256; i++) send(~8'(i));
    stop();
    chk("t2_nwr", wr_total - base, 510);
    bad = 0;
    for (int i = 0; i < 254; i++)
      if (wa[base+i] !== 16'h7000 + 16'(i) || wd[base+i] !== 8'(i))
        bad++;
    for (int i = 0; i < 256; i++)
      if (wa[base+254+i] !== 16'h7000 + 16'(i) ||
          wd[base+254+i] !== ~8'(i))
        bad++;
    chk("t2_content", bad, 0);
    chk("t2_last254", wa[base+253], 16'h70FD);
    chk("t2_last256", wa[base+509], 16'h70FF);
    chk("t2_bc", byte_count, 518);
    chk("t2_nex", ex_total - exb, 0);
    chk("t2_err", error, 0);

    // Unknown record skipped, then a load
    base = wr_total;
    start(8'd2);
    send(8'h05); send(8'h03); send(8'h41); send(8'h42); send(8'h43);
    send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h5A);
    stop();
    chk("t3_nwr", wr_total - base, 1);
    chk("t3_addr", wa[base], 16'h2010);
    chk("t3_data", wd[base], 8'h5A);
    chk("t3_err", error, 0);

    // Address wrap
    base = wr_total;
    start(8'd2);
    send(8'h01); send(8'h04); send(8'hFF); send(8'hFF);
    send(8'h11); send(8'h22);
    stop();
    chk("t4_nwr", wr_total - base, 2);
    chk("t4_a0", wa[base], 16'hFFFF);
    chk("t4_d0", wd[base], 8'h11);
    chk("t4_a1", wa[base+1], 16'h0000);
    chk("t4_d1", wd[base+1], 8'h22);

    // Truncated image, then clean download clears error
    base = wr_total; exb = ex_total;
    start(8'd2);
    send(8'h01); send(8'h06); send(8'h00); send(8'h50);
    send(8'hD1); send(8'hD2);
    stop();
    chk("t5_nwr", wr_total - base, 2);
    chk("t5_err", error, 1);
    chk("t5_nex", ex_total - exb, 0);
    exb = ex_total;
    start(8'd2);
    @(negedge clock);
    chk("t5_clr", error, 0);
    send(8'h02); send(8'h02); send(8'h00); send(8'h60);
    stop();
    chk("t5_nex2", ex_total - exb, 1);
    chk("t5_xaddr", execute_addr, 16'h6000);
    chk("t5_bc", byte_count, 4);

    // Other index is ignored
    base = wr_total; exb = ex_total;
    start(8'd1);
    send(8'h01); send(8'h03); send(8'h00); send(8'h30); send(8'h77);
    @(negedge clock);
    ioctl_wr = 1'b0;
    chk("t6_ld", loader_download, 0);
    stop();
    chk("t6_nwr", wr_total - base, 0);
    chk("t6_nex", ex_total - exb, 0);
    chk("t6_bc", byte_count, 4);
    chk("t6_xaddr", execute_addr, 16'h6000);

    // Reset mid-DATA
    exb = ex_total;
    start(8'd2);
    send(8'h01); send(8'h05); send(8'h00); send(8'h40); send(8'hAA);
    @(negedge clock);
    ioctl_wr = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("t7_wr", loader_wr, 0);
    chk("t7_addr", loader_addr, 0);
    chk("t7_data", loader_data, 0);
    chk("t7_xaddr", execute_addr, 0);
    chk("t7_err", error, 0);
    chk("t7_bc", byte_count, 0);
    chk("t7_ld", loader_download, 0);
    ioctl_download = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("t7_nex", ex_total - exb, 0);
    chk("t7_err2", error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
